// File: rtl/avrspi_master.sv
// avrspi_master: SPI mode-0 master sending one address byte plus len data bytes, MSB first, full duplex
module avrspi_master #(
  parameter int DIV      = 2,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic       fclk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] addr,
  input  logic [7:0] len,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic [7:0] rx_data,
  output logic       rx_stb,
  output logic       busy,
  output logic       done,
  output logic       spics_n,
  output logic       spick,
  output logic       spido,
  input  logic       spidi
);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, FIN} state_t;
  localparam logic [15:0] DIV_M1   = 16'(DIV - 1);
  localparam logic [15:0] SETUP_M1 = 16'(CS_SETUP - 1);
  localparam logic [15:0] HOLD_M1  = 16'(CS_HOLD - 1);
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic        ph_q, ph_d;
  logic        first_q, first_d;
  logic [7:0]  rem_q, rem_d;
  logic [6:0]  sh_q, sh_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  rxd_q, rxd_d;
  logic        rx_stb_q, rx_stb_d;
  logic        tx_req_q, tx_req_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        cs_q, cs_d;
  logic        sck_q, sck_d;
  logic        mosi_q, mosi_d;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    ph_d     = ph_q;
    first_d  = first_q;
    rem_d    = rem_q;
    sh_d     = sh_q;
    rx_d     = rx_q;
    rxd_d    = rxd_q;
    rx_stb_d = 1'b0;
    done_d   = 1'b0;
    busy_d   = busy_q;
    cs_d     = cs_q;
    sck_d    = sck_q;
    mosi_d   = mosi_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = SETUP;
        cnt_d   = '0;
        bit_d   = '0;
        ph_d    = 1'b0;
        first_d = 1'b1;
        rem_d   = len;
        sh_d    = addr[6:0];
        mosi_d  = addr[7];
        busy_d  = 1'b1;
        cs_d    = 1'b0;
      end
      SETUP: begin
        state_d = (cnt_q == SETUP_M1) ? SHIFT : SETUP;
        cnt_d   = (cnt_q == SETUP_M1) ? '0 : cnt_q + 16'd1;
      end
      SHIFT: if (cnt_q != DIV_M1) cnt_d = cnt_q + 16'd1;
      else begin
        cnt_d = '0;
        ph_d  = !ph_q;
        sck_d = !ph_q;
        if (!ph_q) rx_d = {rx_q[6:0], spidi};
        else if (bit_q != 3'd7) begin
          bit_d  = bit_q + 3'd1;
          sh_d   = {sh_q[5:0], 1'b0};
          mosi_d = sh_q[6];
        end else begin
          // byte boundary: the address byte's received bits are dropped
          bit_d    = '0;
          first_d  = 1'b0;
          rx_stb_d = !first_q;
          rxd_d    = first_q ? rxd_q : rx_q;
          if (rem_q != 8'd0) begin
            rem_d  = rem_q - 8'd1;
            sh_d   = tx_data[6:0];
            mosi_d = tx_data[7];
          end else state_d = HOLD;
        end
      end
      HOLD: if (cnt_q != HOLD_M1) cnt_d = cnt_q + 16'd1;
      else begin
        state_d = FIN;
        cs_d    = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        mosi_d  = 1'b0;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // strobe lands on the final high cycle of bit 7, so tx_data is sampled before the boundary load
    tx_req_d = (state_d == SHIFT) && ph_d && (bit_d == 3'd7) && (cnt_d == DIV_M1) && (rem_q != 8'd0);
  end
  always_ff @(posedge fclk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      ph_q     <= 1'b0;
      first_q  <= 1'b0;
      rem_q    <= '0;
      sh_q     <= '0;
      rx_q     <= '0;
      rxd_q    <= '0;
      rx_stb_q <= 1'b0;
      tx_req_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cs_q     <= 1'b1;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      ph_q     <= ph_d;
      first_q  <= first_d;
      rem_q    <= rem_d;
      sh_q     <= sh_d;
      rx_q     <= rx_d;
      rxd_q    <= rxd_d;
      rx_stb_q <= rx_stb_d;
      tx_req_q <= tx_req_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cs_q     <= cs_d;
      sck_q    <= sck_d;
      mosi_q   <= mosi_d;
    end
  end
  assign tx_req  = tx_req_q;
  assign rx_data = rxd_q;
  assign rx_stb  = rx_stb_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign spics_n = cs_q;
  assign spick   = sck_q;
  assign spido   = mosi_q;
endmodule

// File: doc/avrspi_master.md
Name: avrspi_master

Overview:
- SPI mode-0 master that drives a 4-wire link (spics_n/spick/spido/spidi) framed the way our FPGA SPI slave expects: one address byte, then 0..255 data bytes, MSB first, full duplex.
- Used for host-side link bring-up and self-test, and for FPGA-to-FPGA register access.
- Parallel side is a start/busy command port with a per-byte tx fetch strobe and an rx strobe.

Parameters:
- DIV, 2: fclk cycles per SCK half-period (>=1).
- CS_SETUP, 2: fclk cycles from spics_n falling to first SCK rising (>=1).
- CS_HOLD, 2: fclk cycles from last SCK falling to spics_n rising (>=1).

Ports:
- fclk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin frame; sampled only when busy=0.
- addr  in  8  address byte, captured on accepted start.
- len  in  8  number of data bytes after the address, captured on accepted start; 0 is legal.
- tx_data  in  8  next data byte to send; sampled in the tx_req cycle.
- tx_req  out  1  one-cycle pulse: tx_data consumed.
- rx_data  out  8  last received data byte; holds its value until the next rx_stb.
- rx_stb  out  1  one-cycle pulse: rx_data valid.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at end of frame.
- spics_n  out  1  chip select, active-low.
- spick  out  1  SCK, idles low.
- spido  out  1  MOSI.
- spidi  in  1  MISO.

Behaviour:
- Reset values: spics_n=1, spick=0, spido=0, busy=0, done=0, tx_req=0, rx_stb=0, rx_data=0.
- Reset takes priority in every state and applies on the next edge. A frame interrupted by reset produces no done and no further strobes.
- All outputs are registered.
- FSM states: IDLE, SETUP, SHIFT, HOLD, FIN.
- IDLE:
  - start=1 latches addr into the shift register and len into the byte counter.
  - Next cycle: busy=1, spics_n=0, spido=addr[7], go to SETUP.
- SETUP: lasts CS_SETUP cycles with spick=0, then go to SHIFT.
- SHIFT, per bit: DIV cycles spick=0, then DIV cycles spick=1.
  - spidi is sampled on the fclk edge where spick goes 0->1.
  - spido advances to the next bit on the edge where spick goes 1->0. It never changes while spick=1.
- Byte boundary (end of the high phase of bit 7):
  - If more data bytes remain: tx_req=1 for that cycle, the shift register loads tx_data, and spido=tx_data[7] on the same edge spick falls.
  - The address byte's received bits are discarded (no rx_stb).
  - Each data byte's received bits raise rx_stb for one cycle, with rx_data = bits in MSB-first order. This is coincident with the boundary edge.
- After the last byte, go to HOLD.
  - HOLD lasts CS_HOLD cycles with spick=0 and spido holding its last value.
- FIN (one cycle): spics_n=1, done=1, busy=0, spido=0.
  - start in the FIN cycle is ignored, so minimum CS-high time between frames is 2 cycles.
- Byte counter is 8-bit. len=255 sends 256 bytes total, with no wrap to 0.
- start while busy=1 is ignored. Changes to addr/len/tx_data between their sample points are ignored.
- Frame length in fclk cycles, from first spics_n=0 to last spics_n=0: CS_SETUP + (len+1)*16*DIV + CS_HOLD.

Test Plan:
- Defaults, start at cycle 0, addr=0xA5, len=0, spidi tied 1:
  - spics_n low cycles 1..36.
  - 8 SCK rising edges; spido bit sequence 1,0,1,0,0,1,0,1.
  - No rx_stb, no tx_req; done at cycle 37, busy=0.
- addr=0x10, len=2, tx_data supplies 0x3C then 0xC3; slave model returns 0xFF,0x81,0x7E:
  - exactly 2 tx_req pulses, first at end of the address byte.
  - MOSI bytes 0x10,0x3C,0xC3.
  - rx_stb twice with rx_data=0x81, then 0x7E.
- DIV=1, len=255, loopback spido->spidi:
  - 256 rx_stb pulses, each rx_data equal to the byte sent.
  - done after 2+256*16+2 = 4100 CS-low cycles.
- start held high continuously:
  - back-to-back frames with exactly 2 cycles of spics_n=1 between them.
  - start pulses while busy create no extra frames.
- rst asserted mid-SHIFT of byte 1:
  - next cycle spics_n=1, spick=0, busy=0.
  - no done/rx_stb; a later start runs a clean full frame.
- Protocol monitor over random addr/len/DIV:
  - spido stable whenever spick=1.
  - spick=0 whenever spics_n=1.
  - frame length matches the formula.
